// File: rtl/host_to_breakout_tx_if.sv
// Host-side signal bundle for the breakout serializer: frame field inputs and serial outputs.
interface host_to_breakout_tx_if;
    logic        i_enable;
    logic [7:0]  i_port;
    logic        i_acq_running;
    logic        i_acq_reset_done;
    logic [3:0]  i_ledlevel;
    logic [1:0]  i_ledmode;
    logic [1:0]  i_porta_status;
    logic [1:0]  i_portb_status;
    logic [1:0]  i_portc_status;
    logic [1:0]  i_portd_status;
    logic [11:0] i_aio_dir;
    logic [1:0]  i_harp_conf;
    logic [15:0] i_gpio_dir;
    logic        o_clk_s;
    logic        o_d0_s;
    logic        o_frame_start;
    logic        o_busy;

    modport master (
        output i_enable, i_port, i_acq_running, i_acq_reset_done, i_ledlevel, i_ledmode,
               i_porta_status, i_portb_status, i_portc_status, i_portd_status,
               i_aio_dir, i_harp_conf, i_gpio_dir,
        input  o_clk_s, o_d0_s, o_frame_start, o_busy
    );

    modport slave (
        input  i_enable, i_port, i_acq_running, i_acq_reset_done, i_ledlevel, i_ledmode,
               i_porta_status, i_portb_status, i_portc_status, i_portd_status,
               i_aio_dir, i_harp_conf, i_gpio_dir,
        output o_clk_s, o_d0_s, o_frame_start, o_busy
    );
endinterface

// File: rtl/host_to_breakout_tx.sv
// Serializer driving the breakout LVDS_IN pair: free-running forwarded clock plus
// 64-bit MSB-first frames {SYNC, FAST, SLOW}, data updated on forwarded-clock falls.
module host_to_breakout_tx #(
    parameter int unsigned CLK_DIV   = 3,
    parameter logic [7:0]  SYNC_WORD = 8'hB5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    host_to_breakout_tx_if.slave  bus
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic               clk_s;
    logic               div_tc;
    logic               fall;
    logic [63:0]        shift, shift_nxt;
    logic [5:0]         bit_cnt, bit_cnt_nxt;
    logic               busy, busy_nxt;
    logic               frame_start, frame_start_nxt;
    logic [47:0]        slow;
    logic [63:0]        frame;

    assign slow = {bus.i_acq_running, bus.i_acq_reset_done, bus.i_ledlevel, bus.i_ledmode,
                   bus.i_porta_status, bus.i_portb_status, bus.i_portc_status, bus.i_portd_status,
                   bus.i_aio_dir, bus.i_harp_conf, bus.i_gpio_dir, 2'b00};
    assign frame = {SYNC_WORD, bus.i_port, slow};

    assign div_tc = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall   = div_tc && clk_s;

    // Divider is never gated so the breakout PLL stays locked across idle periods.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_cnt <= '0;
            clk_s   <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            clk_s   <= ~clk_s;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift       <= shift_nxt;
            bit_cnt     <= bit_cnt_nxt;
            busy        <= busy_nxt;
            frame_start <= frame_start_nxt;
        end
    end

    // Shift register is cleared whenever idle, so its MSB doubles as the data line.
    always_comb begin
        state_nxt       = state;
        shift_nxt       = shift;
        bit_cnt_nxt     = bit_cnt;
        busy_nxt        = busy;
        frame_start_nxt = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (bus.i_enable) begin
                        shift_nxt       = frame;
                        bit_cnt_nxt     = 6'd63;
                        busy_nxt        = 1'b1;
                        frame_start_nxt = 1'b1;
                        state_nxt       = SEND;
                    end
                end
                SEND: begin
                    if (bit_cnt != 6'd0) begin
                        shift_nxt   = {shift[62:0], 1'b0};
                        bit_cnt_nxt = bit_cnt - 6'd1;
                    end else if (bus.i_enable) begin
                        shift_nxt       = frame;
                        bit_cnt_nxt     = 6'd63;
                        frame_start_nxt = 1'b1;
                    end else begin
                        shift_nxt   = '0;
                        bit_cnt_nxt = 6'd0;
                        busy_nxt    = 1'b0;
                        state_nxt   = IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.o_clk_s       = clk_s;
    assign bus.o_d0_s        = shift[63];
    assign bus.o_frame_start = frame_start;
    assign bus.o_busy        = busy;
endmodule
